// File: rtl/crc8_packet_framer.sv
// Transmit-path byte framer: passes payload bytes through unchanged and appends a
// CRC-8 (MSB-first, non-reflected, no final XOR) computed over the packet's payload.
module crc8_packet_framer #(
   parameter logic [7:0] POLY = 8'h07,
   parameter logic [7:0] INIT = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ready
);

   typedef enum logic {
      PASS   = 1'b0,
      APPEND = 1'b1
   } state_t;

   state_t     state_reg;
   logic [7:0] crc_reg;
   logic [7:0] out_data_reg;
   logic       out_valid_reg;
   logic       out_last_reg;

   logic       free;
   logic       in_accept;
   logic [7:0] crc_next;
   logic [7:0] crc_step [0:8];

   // The output register can take a new beat when it is empty or being drained now.
   assign free      = !out_valid_reg || out_ready;
   assign in_ready  = (state_reg == PASS) && free;
   assign in_accept = in_valid && in_ready;

   // Eight unrolled shift steps of the {1,POLY} division, one per input bit, MSB first.
   assign crc_step[0] = crc_reg ^ in_data;
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bit
         assign crc_step[gi+1] = {crc_step[gi][6:0], 1'b0} ^
                                 (crc_step[gi][7] ? POLY : 8'h00);
      end
   endgenerate
   assign crc_next = crc_step[8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= PASS;
         crc_reg       <= INIT;
         out_data_reg  <= 8'h00;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
      end else begin
         case (state_reg)
            PASS: begin
               if (in_accept) begin
                  out_data_reg  <= in_data;
                  out_last_reg  <= 1'b0;
                  out_valid_reg <= 1'b1;
                  crc_reg       <= crc_next;
                  if (in_last) begin
                     state_reg <= APPEND;
                  end
               end else if (out_valid_reg && out_ready) begin
                  out_valid_reg <= 1'b0;
               end
            end
            APPEND: begin
               // crc_reg already covers the final payload byte accepted in PASS.
               if (free) begin
                  out_data_reg  <= crc_reg;
                  out_last_reg  <= 1'b1;
                  out_valid_reg <= 1'b1;
                  crc_reg       <= INIT;
                  state_reg     <= PASS;
               end
            end
            default: begin
               state_reg <= PASS;
            end
         endcase
      end
   end

   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign out_last  = out_last_reg;

endmodule

// File: tb/tb_crc8_packet_framer.sv
// Scoreboard bench for crc8_packet_framer: expected beats are queued when input bytes
// are accepted and compared as output beats are handed downstream.
module tb_crc8_packet_framer;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_last;
   logic       out_ready;

   int n_compared   = 0;
   int n_mismatched = 0;

   logic [8:0] exp_q [$];
   logic       rand_ready = 1'b0;
   logic       hold_prev  = 1'b0;
   logic [8:0] hold_beat  = 9'h000;
   logic       stall_win  = 1'b0;
   int         stall_cnt  = 0;

   crc8_packet_framer #(
      .POLY(8'h07),
      .INIT(8'h00)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_last  (in_last),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_last (out_last),
      .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Downstream ready: held high, or pseudo-random when rand_ready is set.
   always @(negedge clk) begin
      out_ready <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output monitor: samples mid-cycle, after all inputs have settled.
   always @(negedge clk) begin
      logic [8:0] exp_beat;
      #2;
      if (hold_prev) begin
         check_val("hold_valid", {31'd0, out_valid}, 32'd1);
         check_val("hold_beat", {23'd0, out_last, out_data}, {23'd0, hold_beat});
      end
      if (stall_win && !in_ready) stall_cnt++;
      if (out_valid && out_ready) begin
         $display("beat data=%02h last=%0d", out_data, out_last);
         if (exp_q.size() == 0) begin
            check_val("unexpected_beat", {23'd0, out_last, out_data}, 32'h1ff);
         end else begin
            exp_beat = exp_q.pop_front();
            check_val("beat", {23'd0, out_last, out_data}, {23'd0, exp_beat});
         end
      end
      hold_prev = out_valid && !out_ready && rst_n;
      hold_beat = {out_last, out_data};
   end

   task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
      int budget;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      budget   = 0;
      #1;
      while (!in_ready) begin
         budget++;
         if (budget > 500) begin
            check_val("in_ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_packet(input logic [7:0] bytes [$], input logic [7:0] crc, input int gap);
      for (int i = 0; i < bytes.size(); i++) begin
         exp_q.push_back({1'b0, bytes[i]});
         if (i == bytes.size() - 1) exp_q.push_back({1'b1, crc});
         send_byte(bytes[i], (i == bytes.size() - 1), (i == 0) ? 0 : gap);
      end
   endtask

   task automatic send_open(input logic [7:0] bytes [$]);
      for (int i = 0; i < bytes.size(); i++) begin
         exp_q.push_back({1'b0, bytes[i]});
         send_byte(bytes[i], 1'b0, 0);
      end
   endtask

   task automatic wait_drain;
      int budget;
      budget = 0;
      while (exp_q.size() != 0) begin
         budget++;
         if (budget > 2000) begin
            check_val("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
            return;
         end
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      logic [7:0] p_one [$];
      logic [7:0] p_check [$];
      logic [7:0] p_ff [$];
      logic [7:0] p_00 [$];
      logic [7:0] p_part [$];
      p_one   = '{8'h01};
      p_check = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      p_ff    = '{8'hFF};
      p_00    = '{8'h00};
      p_part  = '{8'h31, 8'h32};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      out_ready = 1'b1;
      #3;
      check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("rst_out_data", {24'd0, out_data}, 32'h00);
      check_val("rst_out_last", {31'd0, out_last}, 32'd0);
      check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      send_packet(p_one, 8'h07, 0);
      wait_drain();
      send_packet(p_check, 8'hF4, 0);
      wait_drain();

      stall_cnt = 0;
      stall_win = 1'b1;
      send_packet(p_ff, 8'hF3, 0);
      send_packet(p_00, 8'h00, 0);
      wait_drain();
      stall_win = 1'b0;
      check_val("stall_cycles", stall_cnt, 32'd2);

      rand_ready = 1'b1;
      send_packet(p_check, 8'hF4, 0);
      wait_drain();
      rand_ready = 1'b0;
      repeat (2) @(negedge clk);

      send_open(p_part);
      wait_drain();
      rst_n = 1'b0;
      #1;
      check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("midrst_out_last", {31'd0, out_last}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send_packet(p_one, 8'h07, 0);
      wait_drain();

      send_packet(p_check, 8'hF4, 3);
      wait_drain();

      check_val("queue_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
